// File: rtl/sw_bank_pkg.sv
// Shared types and sizes for the switch bank loader.
// W is the switch and bank width. NBANK is the number of banks.
// sel_t is the bank select and bank_data_t is the default-width bank word.
package sw_bank_pkg;

    localparam int unsigned W     = 3;
    localparam int unsigned NBANK = 4;

    typedef logic [1:0]   sel_t;
    typedef logic [W-1:0] bank_data_t;

endpackage : sw_bank_pkg

// File: rtl/sw_bank_loader_debounce.sv
// debounce: accepts a new level on `in` only after it has differed from the
// accepted level for DB_CYCLES consecutive clocks. A shorter mismatch is dropped.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   in         : synchronized level to debounce
//   out        : accepted (debounced) level, registered
// Parameter:
//   DB_CYCLES  : stability window in clocks (minimum 1)
module debounce #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count while the input disagrees with the accepted level; any agreement restarts the window.
    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        if (in != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d = in;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign out = out_q;

endmodule : debounce

// File: rtl/sw_bank_loader.sv
// sw_bank_loader: stores a switch value into one of four banks on each
// accepted press of the load button. The clear button empties everything.
// Ports:
//   clk, rst_n       : clock and async active-low reset
//   sw [W-1:0]       : raw switch value to store
//   btn [1:0]        : raw bank select
//   load, clr        : raw pushbuttons, active-high
//   led0..led3       : registered bank contents
//   vld [3:0]        : per-bank written-since-clear flags
//   wr_cnt [7:0]     : accepted-write counter, wraps silently
// Build option: define SW_BANK_LOADER_DEBOUNCE_EN to debounce load over
// DB_CYCLES clocks. Without it the synchronized load is used directly.
module sw_bank_loader #(
    parameter int unsigned W         = sw_bank_pkg::W,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic [1:0]   btn,
    input  logic         load,
    input  logic         clr,
    output logic [W-1:0] led0,
    output logic [W-1:0] led1,
    output logic [W-1:0] led2,
    output logic [W-1:0] led3,
    output logic [3:0]   vld,
    output logic [7:0]   wr_cnt
);

    import sw_bank_pkg::*;

    if (DB_CYCLES < 1) begin : g_db_check
        $error("DB_CYCLES must be at least 1");
    end

    // Two-flop synchronizers
    logic [W-1:0] sw_s1_q, sw_s1_d, sw_s_q, sw_s_d;
    sel_t         sel_s1_q, sel_s1_d, sel_s_q, sel_s_d;
    logic         load_s1_q, load_s1_d, load_s_q, load_s_d;
    logic         clr_s1_q, clr_s1_d, clr_s_q, clr_s_d;

    // Edge detect and storage
    logic               load_db;
    logic               load_db_q, load_db_d;
    logic               wr_c;
    logic [W-1:0]       bank_q [NBANK];
    logic [W-1:0]       bank_d [NBANK];
    logic [NBANK-1:0]   vld_q, vld_d;
    logic [7:0]         wr_cnt_q, wr_cnt_d;

    // Synchronizer next state
    always_comb begin
        sw_s1_d   = sw;
        sw_s_d    = sw_s1_q;
        sel_s1_d  = sel_t'(btn);
        sel_s_d   = sel_s1_q;
        load_s1_d = load;
        load_s_d  = load_s1_q;
        clr_s1_d  = clr;
        clr_s_d   = clr_s1_q;
    end

`ifdef SW_BANK_LOADER_DEBOUNCE_EN
    debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (load_s_q),
        .out   (load_db)
    );
`else
    assign load_db = load_s_q;
`endif

    // One write pulse per accepted rising edge of load
    assign wr_c = load_db & ~load_db_q;

    // Bank update; clear wins over a coincident write
    always_comb begin
        load_db_d = load_db;
        bank_d    = bank_q;
        vld_d     = vld_q;
        wr_cnt_d  = wr_cnt_q;
        if (clr_s_q) begin
            bank_d   = '{default: '0};
            vld_d    = '0;
            wr_cnt_d = '0;
        end else if (wr_c) begin
            bank_d[sel_s_q] = sw_s_q;
            vld_d[sel_s_q]  = 1'b1;
            wr_cnt_d        = wr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q   <= '0;
            sw_s_q    <= '0;
            sel_s1_q  <= '0;
            sel_s_q   <= '0;
            load_s1_q <= 1'b0;
            load_s_q  <= 1'b0;
            clr_s1_q  <= 1'b0;
            clr_s_q   <= 1'b0;
            load_db_q <= 1'b0;
            bank_q    <= '{default: '0};
            vld_q     <= '0;
            wr_cnt_q  <= '0;
        end else begin
            sw_s1_q   <= sw_s1_d;
            sw_s_q    <= sw_s_d;
            sel_s1_q  <= sel_s1_d;
            sel_s_q   <= sel_s_d;
            load_s1_q <= load_s1_d;
            load_s_q  <= load_s_d;
            clr_s1_q  <= clr_s1_d;
            clr_s_q   <= clr_s_d;
            load_db_q <= load_db_d;
            bank_q    <= bank_d;
            vld_q     <= vld_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign led0   = bank_q[0];
    assign led1   = bank_q[1];
    assign led2   = bank_q[2];
    assign led3   = bank_q[3];
    assign vld    = vld_q;
    assign wr_cnt = wr_cnt_q;

endmodule : sw_bank_loader

// File: tb/tb_sw_bank_loader.sv
// Self-checking bench for sw_bank_loader with DB_CYCLES=4.
// It adapts to whether SW_BANK_LOADER_DEBOUNCE_EN is defined.
module tb_sw_bank_loader;

    localparam int DB = 4;
`ifdef SW_BANK_LOADER_DEBOUNCE_EN
    localparam int LAT    = 3 + DB;
    localparam int JIT    = DB;
    localparam int RST_AT = 4;
`else
    localparam int LAT    = 3;
    localparam int JIT    = 0;
    localparam int RST_AT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw;
    logic [1:0] btn;
    logic       load;
    logic       clr;
    logic [2:0] led0, led1, led2, led3;
    logic [3:0] vld;
    logic [7:0] wr_cnt;
    logic [2:0] led_a [4];

    int total = 0;
    int bad   = 0;

    // Reference model: bank contents after every completed transaction
    logic [2:0] m_bank [4];
    logic [3:0] m_vld;
    logic [7:0] m_cnt;

    sw_bank_loader #(.W(3), .DB_CYCLES(DB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw     (sw),
        .btn    (btn),
        .load   (load),
        .clr    (clr),
        .led0   (led0),
        .led1   (led1),
        .led2   (led2),
        .led3   (led3),
        .vld    (vld),
        .wr_cnt (wr_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        led_a[0] = led0;
        led_a[1] = led1;
        led_a[2] = led2;
        led_a[3] = led3;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_bank[i] = 3'd0;
        m_vld = 4'd0;
        m_cnt = 8'd0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        clr   = 1'b0;
        btn   = 2'd0;
        sw    = 3'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        model_clear();
    endtask

    // Press load with the final bank/value; sw/btn wander during the debounce window
    task automatic do_write(input logic [1:0] b, input logic [2:0] v);
        load = 1'b1;
        btn  = b;
        sw   = v;
        for (int i = 0; i < JIT; i++) begin
            btn = 2'($urandom);
            sw  = 3'($urandom);
            tick();
        end
        btn = b;
        sw  = v;
        repeat (LAT + 2 - JIT) tick();
        load = 1'b0;
        repeat (LAT + 2) tick();
        m_bank[b] = v;
        m_vld[b]  = 1'b1;
        m_cnt     = m_cnt + 8'd1;
    endtask

    task automatic test_reset();
        load  = 1'b0;
        clr   = 1'b0;
        btn   = 2'd3;
        sw    = 3'd7;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (led_a[i] !== 3'd0) begin
                $display("FAIL reset_led%0d: got %b want 000", i, led_a[i]);
                bad++;
            end
        end
        total++;
        if (vld !== 4'd0) begin
            $display("FAIL reset_vld: got %b want 0000", vld);
            bad++;
        end
        total++;
        if (wr_cnt !== 8'd0) begin
            $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt);
            bad++;
        end
        apply_reset();
    endtask

    task automatic test_latency();
        apply_reset();
        btn  = 2'd2;
        sw   = 3'b101;
        load = 1'b1;
        repeat (LAT - 1) tick();
        total++;
        if (vld !== 4'd0 || wr_cnt !== 8'd0) begin
            $display("FAIL latency_early: got vld=%b cnt=%0d want 0000/0", vld, wr_cnt);
            bad++;
        end
        tick();
        total++;
        if (led2 !== 3'b101 || vld !== 4'b0100 || wr_cnt !== 8'd1) begin
            $display("FAIL latency_edge: got led2=%b vld=%b cnt=%0d want 101/0100/1", led2, vld, wr_cnt);
            bad++;
        end
        total++;
        if (led0 !== 3'd0 || led1 !== 3'd0 || led3 !== 3'd0) begin
            $display("FAIL latency_others: got %b %b %b want 000", led0, led1, led3);
            bad++;
        end
        load = 1'b0;
        repeat (LAT + 3) tick();
        total++;
        if (wr_cnt !== 8'd1) begin
            $display("FAIL latency_fall: got cnt=%0d want 1", wr_cnt);
            bad++;
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        btn  = 2'd1;
        sw   = 3'd6;
        load = 1'b1;
`ifdef SW_BANK_LOADER_DEBOUNCE_EN
        repeat (DB - 1) tick();
`else
        tick();
        m_bank[1] = 3'd6;
        m_vld[1]  = 1'b1;
        m_cnt     = 8'd1;
`endif
        load = 1'b0;
        repeat (LAT + 4) tick();
        total++;
        if (vld !== m_vld || wr_cnt !== m_cnt || led1 !== m_bank[1]) begin
            $display("FAIL glitch: got vld=%b cnt=%0d led1=%b want %b/%0d/%b",
                     vld, wr_cnt, led1, m_vld, m_cnt, m_bank[1]);
            bad++;
        end
    endtask

    task automatic test_fill();
        apply_reset();
        do_write(2'd0, 3'd1);
        do_write(2'd1, 3'd2);
        do_write(2'd2, 3'd3);
        do_write(2'd3, 3'd4);
        do_write(2'd1, 3'd7);
        total++;
        if (led1 !== 3'd7 || vld !== 4'b1111 || wr_cnt !== 8'd5) begin
            $display("FAIL fill: got led1=%b vld=%b cnt=%0d want 111/1111/5", led1, vld, wr_cnt);
            bad++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (led_a[i] !== m_bank[i]) begin
                $display("FAIL fill_led%0d: got %b want %b", i, led_a[i], m_bank[i]);
                bad++;
            end
        end
    endtask

    task automatic test_clr_coincident();
        apply_reset();
        do_write(2'd0, 3'd3);
        do_write(2'd3, 3'd6);
        btn  = 2'd2;
        sw   = 3'd1;
        load = 1'b1;
        repeat (LAT - 3) tick();
        clr = 1'b1;
        repeat (3) tick();
        clr  = 1'b0;
        load = 1'b0;
        repeat (LAT + 3) tick();
        model_clear();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (led_a[i] !== 3'd0) begin
                $display("FAIL clr_led%0d: got %b want 000", i, led_a[i]);
                bad++;
            end
        end
        total++;
        if (vld !== 4'd0 || wr_cnt !== 8'd0) begin
            $display("FAIL clr_state: got vld=%b cnt=%0d want 0000/0", vld, wr_cnt);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_write(2'd1, 3'd5);
        btn  = 2'd3;
        sw   = 3'd2;
        load = 1'b1;
        repeat (RST_AT) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (led1 !== 3'd0 || vld !== 4'd0 || wr_cnt !== 8'd0) begin
            $display("FAIL rstmid_async: got led1=%b vld=%b cnt=%0d want 000/0000/0", led1, vld, wr_cnt);
            bad++;
        end
        #2;
        rst_n = 1'b1;
        model_clear();
        repeat (LAT - 1) tick();
        total++;
        if (vld !== 4'd0) begin
            $display("FAIL rstmid_early: got vld=%b want 0000", vld);
            bad++;
        end
        tick();
        total++;
        if (led3 !== 3'd2 || vld !== 4'b1000 || wr_cnt !== 8'd1) begin
            $display("FAIL rstmid_write: got led3=%b vld=%b cnt=%0d want 010/1000/1", led3, vld, wr_cnt);
            bad++;
        end
        load = 1'b0;
        repeat (LAT + 3) tick();
        total++;
        if (wr_cnt !== 8'd1) begin
            $display("FAIL rstmid_once: got cnt=%0d want 1", wr_cnt);
            bad++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                clr = 1'b1;
                repeat (3) tick();
                clr = 1'b0;
                repeat (3) tick();
                model_clear();
            end else begin
                do_write(2'($urandom), 3'($urandom));
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (led_a[i] !== m_bank[i]) begin
                    $display("FAIL rand%0d_led%0d: got %b want %b", n, i, led_a[i], m_bank[i]);
                    bad++;
                end
            end
            total++;
            if (vld !== m_vld || wr_cnt !== m_cnt) begin
                $display("FAIL rand%0d_state: got vld=%b cnt=%0d want %b/%0d", n, vld, wr_cnt, m_vld, m_cnt);
                bad++;
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            do_write(2'(i), 3'(i * 5));
            if (i == 254) begin
                total++;
                if (wr_cnt !== 8'd255) begin
                    $display("FAIL wrap_255: got cnt=%0d want 255", wr_cnt);
                    bad++;
                end
            end
        end
        total++;
        if (wr_cnt !== 8'd0 || m_cnt !== 8'd0) begin
            $display("FAIL wrap_0: got cnt=%0d want 0", wr_cnt);
            bad++;
        end
        total++;
        if (vld !== 4'b1111 || led3 !== m_bank[3]) begin
            $display("FAIL wrap_state: got vld=%b led3=%b want 1111/%b", vld, led3, m_bank[3]);
            bad++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        clr   = 1'b0;
        btn   = 2'd0;
        sw    = 3'd0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_latency();
        test_glitch();
        test_fill();
        test_clr_coincident();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sw_bank_loader
